sinegen_dds: RTL

SINEGEN_DDS -- requirements
Module: sinegen_dds

---
 rtl/sinegen_pkg.sv | 64 ++++++
 rtl/sinegen_dds_if.sv | 26 ++
 rtl/sinegen_rom.sv | 71 +++++++
 rtl/sinegen_dds.sv | 62 ++++++
 4 files changed

// File: rtl/sinegen_pkg.sv
// Shared constants and the sine-table generator for the sinegen DDS.
// Table values come from a fixed-point Taylor series evaluated at elaboration time.
package sinegen_pkg;

    localparam int DEF_ACC_W  = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam int MIDSCALE = 2 ** (DEF_DATA_W - 1);

    localparam string ROM_FILE_FULL    = "sinerom.mem";
    localparam string ROM_FILE_QUARTER = "sinerom_q.mem";

    // Q2.30 fixed point keeps x*x inside 64 bits for any angle up to pi/2.
    localparam int     FX_FRAC = 30;
    localparam longint FX_HALF = 64'sd536870912;
    localparam longint FX_PI   = 64'sd3373259426;

    function automatic int unsigned midscale(input int data_w);
        return 2 ** (data_w - 1);
    endfunction

    // sin(2*pi*m / 2^addr_w) in Q2.30, valid for 0 <= m <= 2^(addr_w-2).
    function automatic longint quarter_sine_fx(input int m, input int addr_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (FX_PI * longint'(m) * 64'sd2) >>> addr_w;
        x2   = (x * x) >>> FX_FRAC;
        term = x;
        sum  = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> FX_FRAC) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // T[k] = mid + round((mid-1) * sin(2*pi*k/2^addr_w)), built from first-quadrant values.
    function automatic int sine_sample(input int k, input int addr_w, input int data_w);
        int     n;
        int     half;
        int     qtr;
        int     kk;
        int     m;
        int     mid;
        bit     neg;
        longint r;
        n    = 1 << addr_w;
        half = n / 2;
        qtr  = n / 4;
        mid  = 1 << (data_w - 1);
        kk   = k % n;
        neg  = (kk >= half);
        if (neg) begin
            kk = kk - half;
        end
        m = (kk > qtr) ? (half - kk) : kk;
        r = (longint'(mid - 1) * quarter_sine_fx(m, addr_w) + FX_HALF) >>> FX_FRAC;
        return neg ? (mid - int'(r)) : (mid + int'(r));
    endfunction

endpackage

// File: rtl/sinegen_dds_if.sv
// Control/sample bundle between a DDS consumer (master) and sinegen_dds (slave).
interface sinegen_dds_if #(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic              en;
    logic [ACC_W-1:0]  incr;
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic              valid;
    logic              wrap;

    modport master (
        output en, incr, offset,
        input  dout1, dout2, valid, wrap
    );

    modport slave (
        input  en, incr, offset,
        output dout1, dout2, valid, wrap
    );

endinterface

// File: rtl/sinegen_rom.sv
// Dual-read-port synchronous sine ROM with registered outputs.
// Define SINEGEN_QUARTER_WAVE_EN to store one quadrant and fold the address.
module sinegen_rom
    import sinegen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2
);

    logic [DATA_W-1:0] w_val1;
    logic [DATA_W-1:0] w_val2;

`ifdef SINEGEN_QUARTER_WAVE_EN
    localparam int QTR   = 2 ** (ADDR_W - 2);
    localparam int IDX_W = ADDR_W - 1;

    logic [DATA_W-1:0] w_rom [QTR+1];

    for (genvar g = 0; g <= QTR; g++) begin : g_rom
        localparam logic [DATA_W-1:0] SAMPLE = DATA_W'(sine_sample(g, ADDR_W, DATA_W));
        assign w_rom[g] = SAMPLE;
    end

    // Quadrants 1 and 3 read the mirrored index; quadrants 2 and 3 are negated about zero.
    function automatic logic [IDX_W-1:0] fold_idx(input logic [ADDR_W-1:0] a);
        logic [IDX_W-1:0] low;
        low = IDX_W'(a[ADDR_W-3:0]);
        return a[ADDR_W-2] ? (IDX_W'(QTR) - low) : low;
    endfunction

    logic [IDX_W-1:0] w_idx1;
    logic [IDX_W-1:0] w_idx2;

    assign w_idx1 = fold_idx(i_addr1);
    assign w_idx2 = fold_idx(i_addr2);
    assign w_val1 = i_addr1[ADDR_W-1] ? ('0 - w_rom[w_idx1]) : w_rom[w_idx1];
    assign w_val2 = i_addr2[ADDR_W-1] ? ('0 - w_rom[w_idx2]) : w_rom[w_idx2];
`else
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [DATA_W-1:0] SAMPLE = DATA_W'(sine_sample(g, ADDR_W, DATA_W));
        assign w_rom[g] = SAMPLE;
    end

    assign w_val1 = w_rom[i_addr1];
    assign w_val2 = w_rom[i_addr2];
`endif

    // NOTE: only the output registers are reset; the table itself is constant and never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data1 <= '0;
            o_data2 <= '0;
        end else if (i_en) begin
            o_data1 <= w_val1;
            o_data2 <= w_val2;
        end
    end

endmodule

// File: rtl/sinegen_dds.sv
// Two-channel DDS sine generator: phase accumulator, channel-2 offset, valid and wrap flags.
// Optional build macro SINEGEN_QUARTER_WAVE_EN selects the quarter-wave ROM.
module sinegen_dds
    import sinegen_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    sinegen_dds_if.slave bus
);

    if (ADDR_W > ACC_W) begin : g_bad_cfg
        $error("sinegen_dds: ADDR_W must not exceed ACC_W");
    end

    logic [ACC_W-1:0]  r_phase;
    logic              r_valid;
    logic              r_wrap;
    logic [ACC_W:0]    w_sum;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;

    // Both addresses come from the phase before this cycle's step.
    assign w_sum = {1'b0, r_phase} + {1'b0, bus.incr};
    assign w_a1  = r_phase[ACC_W-1 -: ADDR_W];
    assign w_a2  = w_a1 + bus.offset;

    // NOTE: non-blocking assignments so every register samples the pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_valid <= bus.en;
            r_wrap  <= bus.en & w_sum[ACC_W];
            if (bus.en) begin
                r_phase <= w_sum[ACC_W-1:0];
            end
        end
    end

    sinegen_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .i_en    (bus.en),
        .i_addr1 (w_a1),
        .i_addr2 (w_a2),
        .o_data1 (bus.dout1),
        .o_data2 (bus.dout2)
    );

    assign bus.valid = r_valid;
    assign bus.wrap  = r_wrap;

endmodule
